// File: rtl/parity_seq_gen.sv
// Odd/even sequence generator: latches [lo, hi] on start and streams every value of the
// requested parity in that range over a valid/ready port, with optional wrap and abort.
module parity_seq_gen #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             wrap,
    input  logic             stop,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] first_r, first_s;
    logic [WIDTH-1:0] hi_r, hi_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic [CNT_W-1:0] idx_r, idx_s;
    logic             wrap_r, wrap_s;
    logic             valid_r, valid_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             err_r, err_s;
    logic [WIDTH:0]   first_ext_s;
    logic [WIDTH:0]   next_ext_s;
    logic             beat_s;

    // mode 0 asks for odd values (lsb 1), mode 1 for even values (lsb 0)
    function automatic logic parity_ok(input logic lsb, input logic even_mode);
        return (lsb == ~even_mode);
    endfunction

    // Next-state and next-output logic; extra top bit keeps lo+1 and data+2 from wrapping
    always_comb begin
        state_s = state_r;
        first_s = first_r;
        hi_s    = hi_r;
        data_s  = data_r;
        idx_s   = idx_r;
        wrap_s  = wrap_r;
        valid_s = valid_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        err_s   = 1'b0;

        if (parity_ok(lo[0], mode)) begin
            first_ext_s = {1'b0, lo};
        end else begin
            first_ext_s = {1'b0, lo} + (WIDTH+1)'(1);
        end
        next_ext_s = {1'b0, data_r} + (WIDTH+1)'(2);
        beat_s     = valid_r & out_ready;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    first_s = first_ext_s[WIDTH-1:0];
                    hi_s    = hi;
                    wrap_s  = wrap;
                    if (first_ext_s > {1'b0, hi}) begin
                        err_s  = 1'b1;
                        done_s = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                        data_s  = first_ext_s[WIDTH-1:0];
                        idx_s   = {CNT_W{1'b0}};
                        valid_s = 1'b1;
                        busy_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                    busy_s  = 1'b0;
                end else if (beat_s) begin
                    if (next_ext_s <= {1'b0, hi_r}) begin
                        data_s = next_ext_s[WIDTH-1:0];
                        idx_s  = idx_r + CNT_W'(1);
                    end else if (wrap_r) begin
                        data_s = first_r;
                        idx_s  = {CNT_W{1'b0}};
                    end else begin
                        state_s = ST_IDLE;
                        valid_s = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            first_r <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            data_r  <= {WIDTH{1'b0}};
            idx_r   <= {CNT_W{1'b0}};
            wrap_r  <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            first_r <= first_s;
            hi_r    <= hi_s;
            data_r  <= data_s;
            idx_r   <= idx_s;
            wrap_r  <= wrap_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_idx   = idx_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_parity_seq_gen.sv
// Scoreboard bench for parity_seq_gen at WIDTH=8: expected beats are queued at start
// and popped as the DUT hands them over.
module tb_parity_seq_gen;

    localparam int W = 8;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] lo = '0;
    logic [W-1:0] hi = '0;
    logic         wrap = 1'b0;
    logic         stop = 1'b0;
    logic         out_ready = 1'b1;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [C-1:0] out_idx;
    logic         busy;
    logic         done;
    logic         err;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] exp_d[$];
    logic [C-1:0] exp_i[$];

    parity_seq_gen #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .lo(lo), .hi(hi),
        .wrap(wrap), .stop(stop), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Check the control/status outputs against a packed {valid,busy,done,err} value
    task automatic check_ctl(input string name, input logic [3:0] expv);
        vectors++;
        if ({out_valid, busy, done, err} !== expv) begin
            miscompares++;
            $display("FAIL %s: got v/b/d/e=%b required %b", name, {out_valid, busy, done, err}, expv);
        end
    endtask

    // Push an arithmetic sequence of expected beats
    task automatic push_seq(input int first, input int last, input int start_idx);
        int k = start_idx;
        for (int v = first; v <= last; v += 2) begin
            exp_d.push_back(W'(v));
            exp_i.push_back(C'(k));
            k++;
        end
    endtask

    // Drive start for one cycle; caller is at a negedge, returns at the next negedge
    task automatic kick(input logic m, input int l, input int h, input logic w, input logic s);
        mode = m; lo = W'(l); hi = W'(h); wrap = w; stop = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    // Consume expected beats; toggle selects the ready pattern 1,0,0,1,0,0,...
    task automatic drain(input int budget, input bit toggle);
        int           cyc = 0;
        bit           stalled = 0;
        logic [W-1:0] held_d = '0;
        logic [C-1:0] held_i = '0;
        while (exp_d.size() > 0 && cyc < budget) begin
            out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL drop: out_valid=%b required 1 (cycle %0d)", out_valid, cyc);
            end else begin
                if (stalled && (out_data !== held_d || out_idx !== held_i)) begin
                    miscompares++;
                    $display("FAIL hold: got %0d/%0d required %0d/%0d", out_data, out_idx, held_d, held_i);
                end
                if (out_ready) begin
                    logic [W-1:0] ed;
                    logic [C-1:0] ei;
                    ed = exp_d.pop_front();
                    ei = exp_i.pop_front();
                    if (out_data !== ed || out_idx !== ei) begin
                        miscompares++;
                        $display("FAIL beat: got data %0d idx %0d required data %0d idx %0d", out_data, out_idx, ed, ei);
                    end
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held_d = out_data;
                    held_i = out_idx;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        if (exp_d.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: %0d beats left required 0", exp_d.size());
            exp_d.delete();
            exp_i.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        check_ctl("reset_ctl", 4'b0000);
        vectors++;
        if (out_data !== '0 || out_idx !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %0d/%0d required 0/0", out_data, out_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_ctl("post_reset", 4'b0000);
    endtask

    task automatic test_odd_basic();
        push_seq(1, 9, 0);
        kick(1'b0, 1, 9, 1'b0, 1'b0);
        check_ctl("odd_start", 4'b1100);
        drain(20, 1'b0);
        check_ctl("odd_done", 4'b0010);
    endtask

    // Start lands in the done cycle together with stop: start must win
    task automatic test_back_to_back();
        push_seq(4, 10, 0);
        kick(1'b1, 3, 10, 1'b0, 1'b1);
        check_ctl("b2b_start", 4'b1100);
        drain(40, 1'b1);
        check_ctl("even_done", 4'b0010);
        @(negedge clk);
        check_ctl("done_one_cycle", 4'b0000);
    endtask

    task automatic test_empty();
        kick(1'b0, 4, 4, 1'b0, 1'b0);
        check_ctl("empty_odd", 4'b0011);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_ctl("empty_odd_after", 4'b0000);
        kick(1'b1, 255, 255, 1'b0, 1'b0);
        check_ctl("empty_even_top", 4'b0011);
        @(negedge clk);
        check_ctl("empty_even_after", 4'b0000);
    endtask

    task automatic test_overflow();
        push_seq(251, 255, 0);
        kick(1'b0, 250, 255, 1'b0, 1'b0);
        drain(20, 1'b0);
        check_ctl("ovf_done", 4'b0010);
        @(negedge clk);
    endtask

    // Wrap restarts with no bubble; start/bound changes mid-run must be ignored
    task automatic test_wrap_stop();
        push_seq(1, 5, 0);
        push_seq(1, 5, 0);
        push_seq(1, 1, 0);
        kick(1'b0, 1, 5, 1'b1, 1'b0);
        start = 1'b1; lo = W'(100); hi = W'(200); mode = 1'b1;
        drain(30, 1'b0);
        start = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== W'(3) || out_idx !== C'(1)) begin
            miscompares++;
            $display("FAIL wrap_pre_stop: got v%b %0d/%0d required v1 3/1", out_valid, out_data, out_idx);
        end
        stop = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_ctl("stop_abort", 4'b0000);
        @(negedge clk);
        check_ctl("stop_no_done", 4'b0000);
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b0;
        kick(1'b0, 1, 9, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check_ctl("rst_mid", 4'b0000);
        vectors++;
        if (out_data !== '0 || out_idx !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_data: got %0d/%0d required 0/0", out_data, out_idx);
        end
        @(negedge clk);
        check_ctl("rst_start_ignored", 4'b0000);
        rst_n = 1'b1;
        mode = 1'b1; lo = W'(6); hi = W'(8); wrap = 1'b0;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        check_ctl("start_after_rst", 4'b1100);
        push_seq(6, 8, 0);
        drain(10, 1'b0);
        check_ctl("after_rst_done", 4'b0010);
    endtask

    initial begin
        test_reset();
        test_odd_basic();
        test_back_to_back();
        test_empty();
        test_overflow();
        test_wrap_stop();
        test_reset_mid_run();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/parity_seq_gen.md
# parity_seq_gen

Parametrised odd/even number sequence generator for the arithmetic-exercise datapath: latches a lower and upper bound on `start`, then streams every odd (or even) value in the inclusive range over a valid/ready output port, one value per accepted beat. It replaces the fixed-width, print-only odd-number block with a clocked, back-pressurable source usable by downstream checkers and accumulators, with selectable parity, optional wrap-around and abort.

## Interface
- `WIDTH`, 32: data width of bounds and output value (≥ 2).
- `CNT_W`, 16: width of the beat index counter.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a sequence; sampled only in IDLE.
- `mode`  in  1  0 = odd values, 1 = even values; latched on `start`.
- `lo`  in  WIDTH  inclusive lower bound, unsigned; latched on `start`.
- `hi`  in  WIDTH  inclusive upper bound, unsigned; latched on `start`.
- `wrap`  in  1  1 = restart from first value after `hi`; latched on `start`.
- `stop`  in  1  abort the running sequence.
- `out_ready`  in  1  downstream accept.
- `out_valid`  out  1  `out_data` valid.
- `out_data`  out  WIDTH  current sequence value.
- `out_idx`  out  CNT_W  beat index of `out_data`, 0-based.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at normal completion or error.
- `err`  out  1  one-cycle pulse: range holds no value of requested parity.

## Operation
- States: IDLE, RUN. Reset (rst_n low at a clock edge) forces IDLE from any state; all outputs 0: out_valid, out_data, out_idx, busy, done, err.
- IDLE + `start`: compute first = lo if lo[0] matches parity (odd: 1, even: 0), else lo+1. Adjustment computed in WIDTH+1 bits; if lo = 2^WIDTH−1 and parity mismatches, or first > hi, the range is empty → err=1, done=1 for one cycle, stay IDLE. Otherwise enter RUN with out_data=first, out_idx=0, out_valid=1, busy=1.
- RUN, beat = out_valid & out_ready:
  - next = out_data + 2 computed in WIDTH+1 bits (no silent wrap past 2^WIDTH−1).
  - next ≤ hi: out_data ← next, out_idx ← out_idx+1 (wraps modulo 2^CNT_W).
  - next > hi and wrap=0: go IDLE, out_valid←0, busy←0, done←1 (one cycle).
  - next > hi and wrap=1: out_data ← first, out_idx ← 0, stay RUN.
- No beat: out_data, out_idx held stable while out_valid=1.
- `stop` in RUN has priority over a coincident beat: go IDLE next cycle, out_valid←0, busy←0, done stays 0, err stays 0. `stop` in IDLE ignored; `stop` and `start` together in IDLE: `start` wins.
- `start` in RUN ignored; bounds changes after latch ignored.
- lo = hi with matching parity: exactly one beat.

## Timing
- `start` sampled at edge N → out_valid=1 from cycle N+1 (latency 1); err/done pulse at N+1 for empty range.
- One value per cycle with out_ready held high; zero bubbles, including across a wrap restart.
- Last beat at edge M → out_valid=0, done=1 during cycle M+1; new `start` accepted at edge M+1.
- `stop` at edge K → out_valid=0 from cycle K+1.
- out_valid never drops without a beat except via `stop` or reset.

## Test plan
- Odd, lo=1, hi=9, wrap=0, out_ready=1 → out_data 1,3,5,7,9 on consecutive cycles, out_idx 0..4, done pulse one cycle after 9, busy low.
- Even, lo=3, hi=10; out_ready toggled 1,0,0,1,… → values 4,6,8,10 each held stable until accepted, no drops/duplicates.
- Empty range: odd lo=4 hi=4; even lo=255 hi=255 with WIDTH=8 → err=1, done=1 one cycle after start, out_valid never high.
- Overflow edge, WIDTH=8, odd lo=250 hi=255 → 251,253,255 then done; no value 1 emitted.
- Wrap=1, odd lo=1 hi=5 → 1,3,5,1,3,…; out_idx resets to 0 at each restart; `stop` mid-stream → out_valid low next cycle, no done.
- rst_n low mid-RUN with out_ready=0 → next cycle all outputs 0, state IDLE; `start` ignored while rst_n low, accepted after release.
